// File: rtl/instruction_utils_pkg.sv
// -----------------------------------------------------------------------------
// instruction_utils
// Shared RV32I definitions for the mini-rv core: opcode and funct constants,
// the decoded instruction enum, and the multi-cycle controller's state and
// mux-select enums.
// No ports; imported by rv32i_decoder and multicycle_ctrl.
// -----------------------------------------------------------------------------
package instruction_utils;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // funct7 values that are legal on OP and on the immediate shifts
   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [5:0] {
      INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
      INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
      INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
      INSTR_SB, INSTR_SH, INSTR_SW,
      INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
      INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
      INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
      INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
      INSTR_ILLEGAL
   } rv32i_instr_e;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXECUTE, MEM, WB, TRAP
   } ctrl_state_e;

   typedef enum logic [1:0] {
      PC_SEL_PLUS4  = 2'b00,
      PC_SEL_BRANCH = 2'b01,
      PC_SEL_JALR   = 2'b10
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_LOAD = 2'b01,
      WB_SEL_PC4  = 2'b10,
      WB_SEL_IMM  = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_e;

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// rv32i_decoder
// Purely combinational RV32I classifier for the multi-cycle controller.
// Ports:
//   i_instr      instruction register contents
//   o_instr_type decoded instruction, INSTR_ILLEGAL for anything not RV32I base
//   o_is_*       class flags, all zero for illegal words
//   o_uses_imm   ALU B operand is the immediate
//   o_rd         destination register index
// -----------------------------------------------------------------------------
module rv32i_decoder
   import instruction_utils::*;
(
   input  logic [31:0]  i_instr,
   output rv32i_instr_e o_instr_type,
   output logic         o_is_load,
   output logic         o_is_store,
   output logic         o_is_branch,
   output logic         o_is_jal,
   output logic         o_is_jalr,
   output logic         o_is_lui,
   output logic         o_is_auipc,
   output logic         o_uses_imm,
   output logic [4:0]   o_rd
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_unusedBits;

   assign w_opcode     = i_instr[6:0];
   assign w_funct3     = i_instr[14:12];
   assign w_funct7     = i_instr[31:25];
   assign o_rd         = i_instr[11:7];
   // Register source fields are consumed by the register file, not here.
   assign w_unusedBits = ^i_instr[24:15];

   // Opcode selects the class, funct3/funct7 pick the instruction. Flags are
   // set per opcode and then wiped if the word turned out to be illegal, so the
   // FSM never sees a class flag alongside INSTR_ILLEGAL.
   always_comb begin
      o_instr_type = INSTR_ILLEGAL;
      o_is_load    = 1'b0;
      o_is_store   = 1'b0;
      o_is_branch  = 1'b0;
      o_is_jal     = 1'b0;
      o_is_jalr    = 1'b0;
      o_is_lui     = 1'b0;
      o_is_auipc   = 1'b0;
      o_uses_imm   = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            o_instr_type = INSTR_LUI;
            o_is_lui     = 1'b1;
            o_uses_imm   = 1'b1;
         end
         OPC_AUIPC: begin
            o_instr_type = INSTR_AUIPC;
            o_is_auipc   = 1'b1;
            o_uses_imm   = 1'b1;
         end
         OPC_JAL: begin
            o_instr_type = INSTR_JAL;
            o_is_jal     = 1'b1;
            o_uses_imm   = 1'b1;
         end
         OPC_JALR: begin
            if (w_funct3 == 3'b000) o_instr_type = INSTR_JALR;
            o_is_jalr  = 1'b1;
            o_uses_imm = 1'b1;
         end
         OPC_BRANCH: begin
            o_is_branch = 1'b1;
            case (w_funct3)
               3'b000:  o_instr_type = INSTR_BEQ;
               3'b001:  o_instr_type = INSTR_BNE;
               3'b100:  o_instr_type = INSTR_BLT;
               3'b101:  o_instr_type = INSTR_BGE;
               3'b110:  o_instr_type = INSTR_BLTU;
               3'b111:  o_instr_type = INSTR_BGEU;
               default: o_instr_type = INSTR_ILLEGAL;
            endcase
         end
         OPC_LOAD: begin
            o_is_load  = 1'b1;
            o_uses_imm = 1'b1;
            case (w_funct3)
               3'b000:  o_instr_type = INSTR_LB;
               3'b001:  o_instr_type = INSTR_LH;
               3'b010:  o_instr_type = INSTR_LW;
               3'b100:  o_instr_type = INSTR_LBU;
               3'b101:  o_instr_type = INSTR_LHU;
               default: o_instr_type = INSTR_ILLEGAL;
            endcase
         end
         OPC_STORE: begin
            o_is_store = 1'b1;
            o_uses_imm = 1'b1;
            case (w_funct3)
               3'b000:  o_instr_type = INSTR_SB;
               3'b001:  o_instr_type = INSTR_SH;
               3'b010:  o_instr_type = INSTR_SW;
               default: o_instr_type = INSTR_ILLEGAL;
            endcase
         end
         OPC_OP_IMM: begin
            o_uses_imm = 1'b1;
            case (w_funct3)
               3'b000:  o_instr_type = INSTR_ADDI;
               3'b010:  o_instr_type = INSTR_SLTI;
               3'b011:  o_instr_type = INSTR_SLTIU;
               3'b100:  o_instr_type = INSTR_XORI;
               3'b110:  o_instr_type = INSTR_ORI;
               3'b111:  o_instr_type = INSTR_ANDI;
               3'b001:  if (w_funct7 == F7_ZERO) o_instr_type = INSTR_SLLI;
               3'b101: begin
                  if (w_funct7 == F7_ZERO)     o_instr_type = INSTR_SRLI;
                  else if (w_funct7 == F7_ALT) o_instr_type = INSTR_SRAI;
               end
               default: o_instr_type = INSTR_ILLEGAL;
            endcase
         end
         OPC_OP: begin
            case ({w_funct7, w_funct3})
               {F7_ZERO, 3'b000}: o_instr_type = INSTR_ADD;
               {F7_ALT,  3'b000}: o_instr_type = INSTR_SUB;
               {F7_ZERO, 3'b001}: o_instr_type = INSTR_SLL;
               {F7_ZERO, 3'b010}: o_instr_type = INSTR_SLT;
               {F7_ZERO, 3'b011}: o_instr_type = INSTR_SLTU;
               {F7_ZERO, 3'b100}: o_instr_type = INSTR_XOR;
               {F7_ZERO, 3'b101}: o_instr_type = INSTR_SRL;
               {F7_ALT,  3'b101}: o_instr_type = INSTR_SRA;
               {F7_ZERO, 3'b110}: o_instr_type = INSTR_OR;
               {F7_ZERO, 3'b111}: o_instr_type = INSTR_AND;
               default:           o_instr_type = INSTR_ILLEGAL;
            endcase
         end
         default: o_instr_type = INSTR_ILLEGAL;
      endcase
      if (o_instr_type == INSTR_ILLEGAL) begin
         o_is_load   = 1'b0;
         o_is_store  = 1'b0;
         o_is_branch = 1'b0;
         o_is_jal    = 1'b0;
         o_is_jalr   = 1'b0;
         o_is_lui    = 1'b0;
         o_is_auipc  = 1'b0;
         o_uses_imm  = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control unit for the mini-rv RV32I core. Sequences
// FETCH/DECODE/EXECUTE/MEM/WB, halts in TRAP on illegal instructions, and
// drives every datapath enable and mux select.
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   instr_i         instruction register contents
//   mem_ready_i     memory handshake completion (only looked at while requesting)
//   branch_taken_i  ALU compare result in EXECUTE
//   mem_*_o         shared memory port request, direction, address mux, size
//   ir_we_o, pc_we_o, pc_sel_o, alu_*_o, rf_we_o, wb_sel_o  datapath controls
//   trap_o          core halted on an illegal instruction
//   pc_reset_o      RESET_PC constant for the PC register
//   instret_o       retired instruction count
// Configuration: define MINIRV_INSTRET_EN to build the retired-instruction
// counter; otherwise instret_o is tied to zero.
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import instruction_utils::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  instr_i,
   input  logic         mem_ready_i,
   input  logic         branch_taken_i,
   output logic         mem_req_o,
   output logic         mem_we_o,
   output logic         mem_addr_sel_o,
   output logic [1:0]   mem_size_o,
   output logic         mem_unsigned_o,
   output logic         ir_we_o,
   output logic         pc_we_o,
   output logic [1:0]   pc_sel_o,
   output logic         alu_a_sel_o,
   output logic         alu_b_sel_o,
   output rv32i_instr_e alu_op_o,
   output logic         rf_we_o,
   output logic [1:0]   wb_sel_o,
   output logic         trap_o,
   output logic [31:0]  pc_reset_o,
   output logic [31:0]  instret_o
);

   ctrl_state_e  r_state;
   ctrl_state_e  w_next_state;
   rv32i_instr_e w_instr_type;
   logic         w_is_load;
   logic         w_is_store;
   logic         w_is_branch;
   logic         w_is_jal;
   logic         w_is_jalr;
   logic         w_is_lui;
   logic         w_is_auipc;
   logic         w_uses_imm;
   logic [4:0]   w_rd;
   logic         w_alu_a_pc;

   rv32i_decoder u_decoder (
      .i_instr      (instr_i),
      .o_instr_type (w_instr_type),
      .o_is_load    (w_is_load),
      .o_is_store   (w_is_store),
      .o_is_branch  (w_is_branch),
      .o_is_jal     (w_is_jal),
      .o_is_jalr    (w_is_jalr),
      .o_is_lui     (w_is_lui),
      .o_is_auipc   (w_is_auipc),
      .o_uses_imm   (w_uses_imm),
      .o_rd         (w_rd)
   );

   assign pc_reset_o = RESET_PC;
   // Only AUIPC and JAL compute from the old PC; everything else uses rs1.
   assign w_alu_a_pc = w_is_auipc | w_is_jal;

   // State register: reset parks the controller in FETCH, which is also the
   // only way out of TRAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= FETCH;
      else     r_state <= w_next_state;
   end

   // Next-state logic: FETCH and MEM wait on the memory handshake, DECODE
   // diverts illegal words to TRAP, EXECUTE routes by instruction class.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         FETCH:   if (mem_ready_i) w_next_state = DECODE;
         DECODE:  w_next_state = (w_instr_type == INSTR_ILLEGAL) ? TRAP : EXECUTE;
         EXECUTE: begin
            if (w_is_load || w_is_store) w_next_state = MEM;
            else if (w_is_branch)        w_next_state = FETCH;
            else                         w_next_state = WB;
         end
         MEM:     if (mem_ready_i) w_next_state = w_is_store ? FETCH : WB;
         WB:      w_next_state = FETCH;
         TRAP:    w_next_state = TRAP;
         default: w_next_state = FETCH;
      endcase
   end

   // Output logic: Moore per state, apart from ir_we_o and the store pc_we_o
   // (qualified by same-cycle mem_ready_i) and the branch pc_sel_o (from
   // branch_taken_i). Everything is forced quiet while rst is high so that a
   // reset during a pending access drops it with no request or write enable.
   // ALU selects stay applied through MEM and WB because the address and the
   // writeback value come straight off the ALU.
   always_comb begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_sel_o = 1'b0;
      mem_size_o     = MEM_BYTE;
      mem_unsigned_o = 1'b0;
      ir_we_o        = 1'b0;
      pc_we_o        = 1'b0;
      pc_sel_o       = PC_SEL_PLUS4;
      alu_a_sel_o    = 1'b0;
      alu_b_sel_o    = 1'b0;
      alu_op_o       = INSTR_ILLEGAL;
      rf_we_o        = 1'b0;
      wb_sel_o       = WB_SEL_ALU;
      trap_o         = 1'b0;
      if (!rst) begin
         case (r_state)
            FETCH: begin
               mem_req_o = 1'b1;
               ir_we_o   = mem_ready_i;
            end
            DECODE: begin
               alu_op_o = w_instr_type;
            end
            EXECUTE: begin
               alu_op_o    = w_instr_type;
               alu_a_sel_o = w_alu_a_pc;
               alu_b_sel_o = w_uses_imm;
               if (w_is_branch) begin
                  pc_we_o  = 1'b1;
                  pc_sel_o = branch_taken_i ? PC_SEL_BRANCH : PC_SEL_PLUS4;
               end
            end
            MEM: begin
               alu_op_o       = w_instr_type;
               alu_a_sel_o    = w_alu_a_pc;
               alu_b_sel_o    = w_uses_imm;
               mem_req_o      = 1'b1;
               mem_addr_sel_o = 1'b1;
               mem_we_o       = w_is_store;
               mem_size_o     = instr_i[13:12];
               mem_unsigned_o = instr_i[14];
               pc_we_o        = w_is_store & mem_ready_i;
            end
            WB: begin
               alu_op_o    = w_instr_type;
               alu_a_sel_o = w_alu_a_pc;
               alu_b_sel_o = w_uses_imm;
               pc_we_o     = 1'b1;
               rf_we_o     = (w_rd != 5'd0);
               if (w_is_jal)       pc_sel_o = PC_SEL_BRANCH;
               else if (w_is_jalr) pc_sel_o = PC_SEL_JALR;
               if (w_is_jal || w_is_jalr) wb_sel_o = WB_SEL_PC4;
               else if (w_is_load)        wb_sel_o = WB_SEL_LOAD;
               else if (w_is_lui)         wb_sel_o = WB_SEL_IMM;
            end
            TRAP: begin
               trap_o = 1'b1;
            end
            default: begin
               trap_o = 1'b0;
            end
         endcase
      end
   end

`ifdef MINIRV_INSTRET_EN
   logic [31:0] r_instret;

   // Every PC write is the final one of its instruction, so it marks
   // retirement. Trapped instructions never write the PC and are not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_instret <= 32'd0;
      else if (pc_we_o) r_instret <= r_instret + 32'd1;
   end

   assign instret_o = r_instret;
`else
   assign instret_o = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Table-driven bench for multicycle_ctrl: each row is one clock cycle of
// stimulus plus the hand-computed outputs for that cycle, followed by
// hand-written sequences for trap, reset during a fetch wait and reset during
// a pending store.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
   import instruction_utils::*;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

   localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
   localparam logic [31:0] I_LW   = 32'h0000_A103;  // lw   x2,0(x1)
   localparam logic [31:0] I_BEQ  = 32'h0000_0463;  // beq  x0,x0,+8
   localparam logic [31:0] I_SW   = 32'h0020_A223;  // sw   x2,4(x1)
   localparam logic [31:0] I_JAL  = 32'h0080_00EF;  // jal  x1,+8
   localparam logic [31:0] I_JALR = 32'h0000_8067;  // jalr x0,0(x1)
   localparam logic [31:0] I_LUI  = 32'h1234_52B7;  // lui  x5,0x12345
   localparam logic [31:0] I_ADD0 = 32'h0020_8033;  // add  x0,x1,x2
   localparam logic [31:0] I_LBU  = 32'h0000_C183;  // lbu  x3,0(x1)
   localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;
   localparam logic [31:0] I_SLLB = 32'h4000_1013;  // slli with funct7=0100000

   typedef struct {
      string        name;
      logic [31:0]  instr;
      logic         ready;
      logic         taken;
      logic         req;
      logic         we;
      logic         msel;
      logic [1:0]   size;
      logic         uns;
      logic         irwe;
      logic         pcwe;
      logic [1:0]   pcsel;
      logic         asel;
      logic         bsel;
      logic         rfwe;
      logic [1:0]   wbsel;
      rv32i_instr_e op;
   } vec_t;

   logic         clk;
   logic         rst;
   logic [31:0]  instr;
   logic         memReady;
   logic         branchTaken;
   logic         memReq;
   logic         memWe;
   logic         memAddrSel;
   logic [1:0]   memSize;
   logic         memUnsigned;
   logic         irWe;
   logic         pcWe;
   logic [1:0]   pcSel;
   logic         aluASel;
   logic         aluBSel;
   rv32i_instr_e aluOp;
   logic         rfWe;
   logic [1:0]   wbSel;
   logic         trap;
   logic [31:0]  pcReset;
   logic [31:0]  instret;

   int          checks;
   int          errors;
   logic [31:0] expInstret;
   vec_t        vecs[$];

   multicycle_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_i        (instr),
      .mem_ready_i    (memReady),
      .branch_taken_i (branchTaken),
      .mem_req_o      (memReq),
      .mem_we_o       (memWe),
      .mem_addr_sel_o (memAddrSel),
      .mem_size_o     (memSize),
      .mem_unsigned_o (memUnsigned),
      .ir_we_o        (irWe),
      .pc_we_o        (pcWe),
      .pc_sel_o       (pcSel),
      .alu_a_sel_o    (aluASel),
      .alu_b_sel_o    (aluBSel),
      .alu_op_o       (aluOp),
      .rf_we_o        (rfWe),
      .wb_sel_o       (wbSel),
      .trap_o         (trap),
      .pc_reset_o     (pcReset),
      .instret_o      (instret)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Counter value the bench expects on instret_o for the current build.
   function automatic logic [31:0] instretExp();
`ifdef MINIRV_INSTRET_EN
      return expInstret;
`else
      return 32'd0;
`endif
   endfunction

   function automatic vec_t mk(input string name, input logic [31:0] ins,
                               input logic rdy, input logic tkn,
                               input logic req, input logic we, input logic msel,
                               input logic [1:0] size, input logic uns,
                               input logic irwe, input logic pcwe,
                               input logic [1:0] pcsel, input logic asel,
                               input logic bsel, input logic rfwe,
                               input logic [1:0] wbsel, input rv32i_instr_e op);
      vec_t v;
      v.name = name; v.instr = ins; v.ready = rdy; v.taken = tkn;
      v.req = req; v.we = we; v.msel = msel; v.size = size; v.uns = uns;
      v.irwe = irwe; v.pcwe = pcwe; v.pcsel = pcsel; v.asel = asel;
      v.bsel = bsel; v.rfwe = rfwe; v.wbsel = wbsel; v.op = op;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      instr       = v.instr;
      memReady    = v.ready;
      branchTaken = v.taken;
   endtask

   task automatic checkOutput(input vec_t v);
      chk({v.name, "/mem_req"},      32'(memReq),      32'(v.req));
      chk({v.name, "/mem_we"},       32'(memWe),       32'(v.we));
      chk({v.name, "/mem_addr_sel"}, 32'(memAddrSel),  32'(v.msel));
      chk({v.name, "/mem_size"},     32'(memSize),     32'(v.size));
      chk({v.name, "/mem_unsigned"}, 32'(memUnsigned), 32'(v.uns));
      chk({v.name, "/ir_we"},        32'(irWe),        32'(v.irwe));
      chk({v.name, "/pc_we"},        32'(pcWe),        32'(v.pcwe));
      chk({v.name, "/pc_sel"},       32'(pcSel),       32'(v.pcsel));
      chk({v.name, "/alu_a_sel"},    32'(aluASel),     32'(v.asel));
      chk({v.name, "/alu_b_sel"},    32'(aluBSel),     32'(v.bsel));
      chk({v.name, "/rf_we"},        32'(rfWe),        32'(v.rfwe));
      chk({v.name, "/wb_sel"},       32'(wbSel),       32'(v.wbsel));
      chk({v.name, "/alu_op"},       32'(aluOp),       32'(v.op));
      chk({v.name, "/trap"},         32'(trap),        32'd0);
      chk({v.name, "/instret"},      instret,          instretExp());
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      expInstret  = 32'd0;
      rst         = 1'b1;
      instr       = 32'd0;
      memReady    = 1'b0;
      branchTaken = 1'b0;

      //       name       instr  rdy tkn  req we ms sz   un ir pw ps    as bs rf wb    op
      vecs.push_back(mk("addi_F", I_ADDI, 1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("addi_D", I_ADDI, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ADDI));
      vecs.push_back(mk("addi_E", I_ADDI, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_ADDI));
      vecs.push_back(mk("addi_W", I_ADDI, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 1, 1, 2'd0, INSTR_ADDI));
      vecs.push_back(mk("lw_F",   I_LW,   1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("lw_D",   I_LW,   0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_LW));
      vecs.push_back(mk("lw_E",   I_LW,   0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_LW));
      vecs.push_back(mk("lw_M0",  I_LW,   0, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_LW));
      vecs.push_back(mk("lw_M1",  I_LW,   0, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_LW));
      vecs.push_back(mk("lw_M2",  I_LW,   0, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_LW));
      vecs.push_back(mk("lw_M3",  I_LW,   1, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_LW));
      vecs.push_back(mk("lw_W",   I_LW,   0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 1, 1, 2'd1, INSTR_LW));
      vecs.push_back(mk("beqT_Fw",I_BEQ,  0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("beqT_F", I_BEQ,  1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("beqT_D", I_BEQ,  0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_BEQ));
      vecs.push_back(mk("beqT_E", I_BEQ,  0, 1, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 0, 0, 0, 2'd0, INSTR_BEQ));
      vecs.push_back(mk("beqN_F", I_BEQ,  1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("beqN_D", I_BEQ,  0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_BEQ));
      vecs.push_back(mk("beqN_E", I_BEQ,  0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, INSTR_BEQ));
      vecs.push_back(mk("sw_F",   I_SW,   1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("sw_D",   I_SW,   0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_SW));
      vecs.push_back(mk("sw_E",   I_SW,   1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_SW));
      vecs.push_back(mk("sw_M0",  I_SW,   0, 0, 1, 1, 1, 2'd2, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_SW));
      vecs.push_back(mk("sw_M1",  I_SW,   1, 0, 1, 1, 1, 2'd2, 0, 0, 1, 2'd0, 0, 1, 0, 2'd0, INSTR_SW));
      vecs.push_back(mk("jal_F",  I_JAL,  1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("jal_D",  I_JAL,  0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_JAL));
      vecs.push_back(mk("jal_E",  I_JAL,  0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 1, 0, 2'd0, INSTR_JAL));
      vecs.push_back(mk("jal_W",  I_JAL,  0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 1, 1, 1, 2'd2, INSTR_JAL));
      vecs.push_back(mk("jalr_F", I_JALR, 1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("jalr_D", I_JALR, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_JALR));
      vecs.push_back(mk("jalr_E", I_JALR, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_JALR));
      vecs.push_back(mk("jalr_W", I_JALR, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 0, 1, 0, 2'd2, INSTR_JALR));
      vecs.push_back(mk("lui_F",  I_LUI,  1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("lui_D",  I_LUI,  0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_LUI));
      vecs.push_back(mk("lui_E",  I_LUI,  0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_LUI));
      vecs.push_back(mk("lui_W",  I_LUI,  0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 1, 1, 2'd3, INSTR_LUI));
      vecs.push_back(mk("add0_F", I_ADD0, 1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("add0_D", I_ADD0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ADD));
      vecs.push_back(mk("add0_E", I_ADD0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ADD));
      vecs.push_back(mk("add0_W", I_ADD0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, INSTR_ADD));
      vecs.push_back(mk("lbu_F",  I_LBU,  1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_ILLEGAL));
      vecs.push_back(mk("lbu_D",  I_LBU,  0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, INSTR_LBU));
      vecs.push_back(mk("lbu_E",  I_LBU,  0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_LBU));
      vecs.push_back(mk("lbu_M",  I_LBU,  1, 0, 1, 0, 1, 2'd0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd0, INSTR_LBU));
      vecs.push_back(mk("lbu_W",  I_LBU,  0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 1, 1, 2'd1, INSTR_LBU));

      // Reset held across a rising edge: everything at reset values.
      @(negedge clk);
      chk("rst/mem_req",  32'(memReq),  32'd0);
      chk("rst/ir_we",    32'(irWe),    32'd0);
      chk("rst/pc_we",    32'(pcWe),    32'd0);
      chk("rst/rf_we",    32'(rfWe),    32'd0);
      chk("rst/mem_we",   32'(memWe),   32'd0);
      chk("rst/pc_sel",   32'(pcSel),   32'd0);
      chk("rst/wb_sel",   32'(wbSel),   32'd0);
      chk("rst/alu_op",   32'(aluOp),   32'(INSTR_ILLEGAL));
      chk("rst/trap",     32'(trap),    32'd0);
      chk("rst/pc_reset", pcReset,      TB_RESET_PC);
      chk("rst/instret",  instret,      32'd0);

      // First cycle after release is already requesting the fetch.
      rst = 1'b0;
      #1;
      chk("rel/mem_req",      32'(memReq),     32'd1);
      chk("rel/mem_addr_sel", 32'(memAddrSel), 32'd0);

      // Table of per-cycle vectors; retirement tracked from expected pc_we.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput(vecs[i]);
         if (vecs[i].pcwe) expInstret = expInstret + 32'd1;
         @(negedge clk);
      end
      #1;
      chk("table_end/instret", instret, instretExp());

      // Illegal 32'hFFFF_FFFF: FETCH, DECODE, then TRAP held for 100 cycles
      // with memReady toggling to show it is ignored.
      instr = I_BAD; memReady = 1'b1; branchTaken = 1'b0;
      #1;
      chk("bad_F/ir_we", 32'(irWe), 32'd1);
      @(negedge clk);
      memReady = 1'b0;
      #1;
      chk("bad_D/trap",   32'(trap),  32'd0);
      chk("bad_D/alu_op", 32'(aluOp), 32'(INSTR_ILLEGAL));
      @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         memReady = i[0];
         #1;
         chk($sformatf("trap_hold%0d/trap", i), 32'(trap), 32'd1);
         chk($sformatf("trap_hold%0d/quiet", i),
             32'({memReq, memWe, irWe, pcWe, rfWe}), 32'd0);
         @(negedge clk);
      end
      chk("trap_done/instret", instret, instretExp());

      // Reset leaves TRAP and clears the counter.
      rst = 1'b1; memReady = 1'b0;
      expInstret = 32'd0;
      #1;
      chk("trap_rst/trap",    32'(trap),   32'd0);
      chk("trap_rst/mem_req", 32'(memReq), 32'd0);
      chk("trap_rst/instret", instret,     32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("trap_rel/mem_req", 32'(memReq), 32'd1);

      // Illegal funct7 on SLLI also traps right after DECODE.
      instr = I_SLLB; memReady = 1'b1;
      @(negedge clk);
      memReady = 1'b0;
      @(negedge clk);
      #1;
      chk("slli_bad/trap",    32'(trap),   32'd1);
      chk("slli_bad/mem_req", 32'(memReq), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Reset pulsed during a FETCH wait: request dropped, no IR write even
      // with memReady high, and FETCH resumes afterwards.
      instr = I_SW; memReady = 1'b0;
      #1;
      chk("fwait/mem_req", 32'(memReq), 32'd1);
      chk("fwait/ir_we",   32'(irWe),   32'd0);
      rst = 1'b1; memReady = 1'b1;
      #1;
      chk("fwait_rst/ir_we",   32'(irWe),   32'd0);
      chk("fwait_rst/mem_req", 32'(memReq), 32'd0);
      @(negedge clk);
      rst = 1'b0; memReady = 1'b0;
      #1;
      chk("fwait_rel/mem_req", 32'(memReq), 32'd1);
      chk("fwait_rel/ir_we",   32'(irWe),   32'd0);
      memReady = 1'b1;
      #1;
      chk("fwait_go/ir_we", 32'(irWe), 32'd1);

      // Store reaches MEM with no ready, then reset lands mid-access.
      @(negedge clk);
      memReady = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("sw_pend/mem_we",  32'(memWe),  32'd1);
      chk("sw_pend/pc_we",   32'(pcWe),   32'd0);
      rst = 1'b1; memReady = 1'b1;
      #1;
      chk("sw_rst/quiet", 32'({memReq, memWe, pcWe, rfWe, irWe}), 32'd0);
      @(negedge clk);
      rst = 1'b0; memReady = 1'b0;
      #1;
      chk("sw_rel/mem_req",      32'(memReq),     32'd1);
      chk("sw_rel/mem_addr_sel", 32'(memAddrSel), 32'd0);
      chk("sw_rel/instret",      instret,         32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the mini-rv RV32I core. It sequences fetch, decode, execute, memory and writeback through a state machine, and drives all datapath enables and muxes. It runs the single shared instruction/data memory port through a req/ready handshake, and halts on illegal instructions. It sits between the instruction register, ALU, register file, PC register and the memory interface.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; output on pc_reset_o.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_i  in  32  instruction register contents (valid from DECODE onward)
- mem_ready_i  in  1  memory accepted/completed current request (same cycle as mem_req_o)
- branch_taken_i  in  1  ALU compare result for the current branch, valid in EXECUTE
- mem_req_o  out  1  memory request; held until mem_ready_i
- mem_we_o  out  1  store request (valid with mem_req_o)
- mem_addr_sel_o  out  1  0 = PC, 1 = ALU result
- mem_size_o  out  2  00 byte, 01 half, 10 word (from funct3)
- mem_unsigned_o  out  1  zero-extend load data (LBU/LHU)
- ir_we_o  out  1  latch instruction word and old PC
- pc_we_o  out  1  PC register write enable
- pc_sel_o  out  2  00 old_pc+4, 01 old_pc+imm (branch/JAL), 10 ALU result & ~1 (JALR)
- alu_a_sel_o  out  1  0 = rs1, 1 = old PC
- alu_b_sel_o  out  1  0 = rs2, 1 = immediate
- alu_op_o  out  rv32i_instr_e  decoded instruction driving ALU function
- rf_we_o  out  1  register file write enable
- wb_sel_o  out  2  00 ALU, 01 load data, 10 old_pc+4, 11 immediate (LUI)
- trap_o  out  1  illegal instruction seen; core halted
- pc_reset_o  out  32  RESET_PC constant for the PC register reset
- instret_o  out  32  retired instruction count (see Configuration)

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Reset state is FETCH.
- FETCH: mem_req_o=1, mem_addr_sel_o=0, mem_we_o=0. On mem_ready_i, assert ir_we_o and go to DECODE. Otherwise stay and keep the request asserted.
- DECODE: the combinational decoder classifies instr_i. INSTR_ILLEGAL goes to TRAP; everything else goes to EXECUTE. Illegal covers unknown opcode, bad funct3, bad funct7 on OP / SRLI/SRAI / SLLI, and JALR funct3≠0.
- EXECUTE: ALU operand selects are driven per class.
  - OP, OP_IMM, LUI, AUIPC, JAL, JALR go to WB.
  - LOAD and STORE go to MEM.
  - BRANCH: pc_we_o=1, pc_sel_o = branch_taken_i ? 01 : 00, then FETCH.
- MEM: mem_req_o=1, mem_addr_sel_o=1, mem_we_o=1 for stores. mem_size_o and mem_unsigned_o come from funct3.
  - On mem_ready_i, a store asserts pc_we_o (sel 00) and goes to FETCH; a load goes to WB.
  - Otherwise the state holds with request signals stable.
- WB: rf_we_o=1 unless rd==0, and pc_we_o=1. Then FETCH.
  - pc_sel_o: 01 for JAL, 10 for JALR, 00 otherwise.
  - wb_sel_o: 10 for JAL/JALR, 01 for loads, 11 for LUI, 00 otherwise.
- TRAP: every enable and request is 0 and trap_o=1. Only rst leaves TRAP.
- Retirement is counted on the cycle the last PC write of the instruction happens.

## Timing
- Reset values: state FETCH. All enables and requests 0. alu_op_o=INSTR_ILLEGAL. Selects 0. trap_o=0. instret_o=0.
  - mem_req_o rises in the first cycle after reset deassertion.
- Cycles per instruction with zero-wait memory (mem_ready_i high in the request cycle):
  - ALU, LUI, AUIPC, JAL, JALR: 4
  - load: 5
  - store: 4
  - branch: 3
- Each wait cycle adds one cycle in FETCH or MEM.
- mem_ready_i is ignored when mem_req_o=0.
- Outputs are Moore per state, except these, which are combinational from same-cycle inputs:
  - ir_we_o (gated by mem_ready_i)
  - store pc_we_o (gated by mem_ready_i)
  - branch pc_sel_o (from branch_taken_i)
- rst asserted mid-operation (including during a pending memory request) forces FETCH immediately. The in-flight access is dropped, with no write enables asserted.

## Configuration
- MINIRV_INSTRET_EN defined: instret_o is a 32-bit counter that increments once per retired instruction and wraps from 32'hFFFF_FFFF to 0. Trapped instructions do not count.
- MINIRV_INSTRET_EN undefined: instret_o is tied to 0 and no counter logic is present.

## Structure
- instruction_utils package gains:
  - ctrl_state_e (FETCH…TRAP)
  - pc_sel_e, wb_sel_e and mem_size_e enums plus their constants
  - existing opcode/funct constants and rv32i_instr_e, reused unchanged
- Sub-module rv32i_decoder: combinational, instr_i in; outputs rv32i_instr_e, class flags (is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, uses_imm) and rd.

## Test plan
- Reset with rst high across a clock edge: all outputs at reset values. First cycle after release: mem_req_o=1, mem_addr_sel_o=0.
- ADDI x1,x0,5 (32'h0050_0093), zero-wait: 4 cycles. rf_we_o=1 in WB with wb_sel_o=00, alu_b_sel_o=1. instret_o goes 0→1 with the macro defined.
- LW x2,0(x1) with mem_ready_i held low for 3 MEM cycles: mem_req_o, mem_addr_sel_o=1 and mem_size_o=10 stay stable. WB follows one cycle after ready, with wb_sel_o=01. Total 8 cycles.
- BEQ x0,x0,+8 (32'h0000_0463) with branch_taken_i=1: 3 cycles, pc_we_o=1 and pc_sel_o=01 in EXECUTE, no rf_we_o. Same instruction with branch_taken_i=0: pc_sel_o=00.
- Illegal word 32'hFFFF_FFFF: TRAP entered after DECODE, trap_o=1 and held for 100 cycles with no mem_req_o. rst returns to FETCH and clears trap_o.
- ADD x0,x1,x2: rf_we_o stays 0 in WB. rst pulsed during a FETCH wait: the next cycle is FETCH with ir_we_o=0.
